// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - interrupt request capture, masking and one-at-a-time ID presentation
//
// Latches eight raw request lines into a pending register and applies a
// software mask. Presents the highest-index eligible request as a 3-bit ID
// with a valid/ack handshake. The pending bit of the presented ID is cleared
// on acknowledge.
//
// Configuration macro: IRQ_EDGE_DETECT_EN
//   defined   - an event is a rising edge of req (req & ~previous req)
//   undefined - an event is the level of req (re-pends while high)
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   req        in   8  raw request lines, bit n = source n
//   mask_wr    in   1  load mask_in into the mask register this cycle
//   mask_in    in   8  new mask value, 1 = source blocked
//   mask       out  8  current mask register
//   pending    out  8  current pending register
//   irq_valid  out  1  irq_id is presenting a request
//   irq_id     out  3  index of the presented request
//   irq_ack    in   1  consumer accepts the presented request
//   overflow   out  1  one-cycle pulse: event merged into an already-pending source

module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  output logic [7:0] mask,
  output logic [7:0] pending,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ack,
  output logic       overflow
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic       overflow_q, overflow_d;

  logic [7:0] event_w;
  logic [7:0] clr_w;
  logic [7:0] eligible_w;
  logic [2:0] sel_w;
  logic       any_eligible_w;
  logic       handshake_w;

`ifdef IRQ_EDGE_DETECT_EN
  // Previous request levels; reset to 0 so a line held high through reset
  // release still produces exactly one event.
  logic [7:0] req_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev_q <= 8'h00;
    end else begin
      req_prev_q <= req;
    end
  end

  assign event_w = req & ~req_prev_q;
`else
  assign event_w = req;
`endif

  assign handshake_w = (state_q == S_PRESENT) && irq_ack;

  // Only the presented bit is cleared, and only on a real handshake.
  assign clr_w = handshake_w ? (8'd1 << irq_id_q) : 8'd0;

  assign eligible_w     = pending_q & ~mask_q;
  assign any_eligible_w = |eligible_w;

  // Highest set index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    sel_w = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible_w[i]) begin
        sel_w = i[2:0];
      end
    end
  end

  always_comb begin
    // Set after clear, so a same-cycle event keeps the bit pending.
    pending_d  = (pending_q & ~clr_w) | event_w;
    overflow_d = |(event_w & pending_q & ~clr_w);
    mask_d     = mask_wr ? mask_in : mask_q;
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      S_IDLE: begin
        // Selection uses the registered mask, so a mask write landing this
        // cycle only affects the next selection.
        if (any_eligible_w) begin
          irq_id_d = sel_w;
          state_d  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // No preemption and no retraction: only an ack leaves this state.
        if (irq_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= 8'h00;
      mask_q     <= 8'h00;
      irq_id_q   <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_id_q   <= irq_id_d;
      overflow_q <= overflow_d;
    end
  end

  assign mask      = mask_q;
  assign pending   = pending_q;
  assign irq_valid = (state_q == S_PRESENT);
  assign irq_id    = irq_id_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - scoreboard bench for irq_pending_ctrl

module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ack;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_q[$];

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask_wr   (mask_wr),
    .mask_in   (mask_in),
    .mask      (mask),
    .pending   (pending),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a presentation, then acknowledge it for one edge.
  task automatic ack_one();
    for (int i = 0; i < 20 && !irq_valid; i++) cyc();
    chk("ack_wait_valid", {31'd0, irq_valid}, 32'd1);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_req(input logic [7:0] v);
    req = v;
    cyc();
    req = 8'h00;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_in = v;
    mask_wr = 1'b1;
    cyc();
    mask_wr = 1'b0;
  endtask

  // Monitor: compares every accepted ID against the scoreboard and checks
  // that a presented ID never changes before it is acknowledged.
  logic       hold_v = 1'b0;
  logic [2:0] hold_id = 3'd0;

  always @(negedge clk) begin
    if (rst !== 1'b1 && irq_valid === 1'b1) begin
      if (hold_v) begin
        chk("id_stable", {29'd0, irq_id}, {29'd0, hold_id});
      end
      if (irq_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_id", {29'd0, irq_id}, 32'hFFFF_FFFF);
        end else begin
          chk("ack_id", {29'd0, irq_id}, {29'd0, exp_q.pop_front()});
        end
      end
    end
    hold_v  = (irq_valid === 1'b1) && (irq_ack !== 1'b1) && (rst !== 1'b1);
    hold_id = irq_id;
  end

  initial begin
    rst     = 1'b1;
    req     = 8'hFF;
    mask_wr = 1'b0;
    mask_in = 8'h00;
    irq_ack = 1'b0;

    // Reset with all requests high: nothing may be captured.
    cyc();
    chk("rst_pending",   {24'd0, pending},   32'h00);
    chk("rst_valid",     {31'd0, irq_valid}, 32'd0);
    chk("rst_id",        {29'd0, irq_id},    32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    chk("rst_mask",      {24'd0, mask},      32'h00);
    rst = 1'b0;
    req = 8'h00;
    cyc();
    cyc();
    chk("post_rst_pending", {24'd0, pending}, 32'h00);

    // Priority and latency: 0x25 -> IDs 5, 2, 0.
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd0);
    pulse_req(8'h25);
    chk("lat_pending",   {24'd0, pending},   32'h25);
    chk("lat_valid_lo",  {31'd0, irq_valid}, 32'd0);
    cyc();
    chk("lat_valid_hi",  {31'd0, irq_valid}, 32'd1);
    chk("lat_id5",       {29'd0, irq_id},    32'd5);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("bubble_valid",  {31'd0, irq_valid}, 32'd0);
    chk("bubble_pending",{24'd0, pending},   32'h05);
    cyc();
    chk("next_valid",    {31'd0, irq_valid}, 32'd1);
    chk("next_id2",      {29'd0, irq_id},    32'd2);
    ack_one();
    ack_one();
    cyc();
    chk("drain_valid",   {31'd0, irq_valid}, 32'd0);
    chk("drain_pending", {24'd0, pending},   32'h00);

    // Masking: bit 7 blocked stays pending; unmasking makes it eligible.
    write_mask(8'h80);
    chk("mask_80",       {24'd0, mask},      32'h80);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd7);
    pulse_req(8'h82);
    chk("mask_pending",  {24'd0, pending},   32'h82);
    ack_one();
    cyc();
    chk("masked_kept",   {24'd0, pending},   32'h80);
    chk("masked_idle",   {31'd0, irq_valid}, 32'd0);
    write_mask(8'h00);
    chk("old_mask_used", {31'd0, irq_valid}, 32'd0);
    chk("mask_00",       {24'd0, mask},      32'h00);
    cyc();
    chk("unmask_valid",  {31'd0, irq_valid}, 32'd1);
    chk("unmask_id7",    {29'd0, irq_id},    32'd7);
    ack_one();

    // No preemption: 6 arrives while 2 is presented.
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd6);
    pulse_req(8'h04);
    cyc();
    chk("np_id2",        {29'd0, irq_id},    32'd2);
    pulse_req(8'h40);
    cyc();
    cyc();
    chk("np_still2",     {29'd0, irq_id},    32'd2);
    chk("np_pending",    {24'd0, pending},   32'h44);
    ack_one();
    ack_one();

    // Set wins over clear in the ack cycle; no overflow from it.
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    pulse_req(8'h08);
    cyc();
    chk("sw_id3",        {29'd0, irq_id},    32'd3);
    req     = 8'h08;
    irq_ack = 1'b1;
    cyc();
    req     = 8'h00;
    irq_ack = 1'b0;
    chk("sw_pending",    {24'd0, pending},   32'h08);
    chk("sw_no_ovf",     {31'd0, overflow},  32'd0);
    chk("sw_bubble",     {31'd0, irq_valid}, 32'd0);
    cyc();
    chk("sw_repres",     {31'd0, irq_valid}, 32'd1);
    ack_one();

    // Overflow: second event on a masked, pending source.
    cyc();
    write_mask(8'h10);
    pulse_req(8'h10);
    chk("ovf_pending",   {24'd0, pending},   32'h10);
    chk("ovf_first",     {31'd0, overflow},  32'd0);
    cyc();
    pulse_req(8'h10);
    chk("ovf_pulse",     {31'd0, overflow},  32'd1);
    cyc();
    chk("ovf_one_cycle", {31'd0, overflow},  32'd0);
    exp_q.push_back(3'd4);
    write_mask(8'h00);
    ack_one();

    // Reset mid-operation.
    cyc();
    write_mask(8'h01);
    pulse_req(8'hC0);
    cyc();
    chk("mid_valid",     {31'd0, irq_valid}, 32'd1);
    chk("mid_pending",   {24'd0, pending},   32'hC0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_pending",  {24'd0, pending},   32'h00);
    chk("mid_rst_valid",    {31'd0, irq_valid}, 32'd0);
    chk("mid_rst_id",       {29'd0, irq_id},    32'd0);
    chk("mid_rst_overflow", {31'd0, overflow},  32'd0);
    chk("mid_rst_mask",     {24'd0, mask},      32'h00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_rst_quiet", {31'd0, irq_valid}, 32'd0);
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
